// File: rtl/imem_boot_loader_if.sv
// Byte-link and instruction-memory write port bundle for imem_boot_loader.
// master = the loader, slave = the surrounding link/memory environment.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: turns a length-prefixed byte frame into big-endian 32-bit imem writes
// and holds the CPU until the program is in. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// LEN_HI | expecting word-count high byte
// LEN_LO | expecting word-count low byte, length validated here
// DATA   | collecting payload bytes, one imem write per 4 bytes
// CHK    | expecting XOR checksum byte (checksum build only)
// DONE   | program loaded, CPU released
// ERR    | load aborted, CPU held
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    imem_boot_loader_if.master    bus,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int          CW    = ADDR_WIDTH + 1;
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_q, word_d;
    logic [CW-1:0]         word_count_q, word_count_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  in_ready_q, in_ready_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic [7:0]            chk_q, chk_d;
    logic                  xfer;
    logic [CW-1:0]         wc_inc;

    assign xfer   = bus.in_valid && in_ready_q;
    assign wc_inc = word_count_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        word_count_d = word_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        chk_d        = chk_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d      = S_LEN_HI;
                    word_count_d = '0;
                    chk_d        = 8'h00;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = bus.in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d        = {len_hi_q, bus.in_data};
                    byte_idx_d   = 2'd0;
                    word_count_d = '0;
                    if (len_d == 16'd0 || {1'b0, len_d} > MAX_W) state_d = S_ERR;
                    else                                          state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d     = {word_q[23:0], bus.in_data};
                    chk_d      = chk_q ^ bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = word_d;
                        word_count_d = wc_inc;
                        if (16'(wc_inc) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
            S_CHK: begin
                if (xfer) state_d = (bus.in_data == chk_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they register alongside it.
        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                     (state_d == S_DATA)   || (state_d == S_CHK);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= 8'h00;
            len_q        <= 16'h0000;
            byte_idx_q   <= 2'd0;
            word_q       <= 32'h0;
            word_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            chk_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            word_count_q <= word_count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            in_ready_q   <= in_ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
            chk_q        <= chk_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = word_count_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected imem writes are queued as frames are sent,
// a negedge monitor pops and compares every imem_we pulse.
module tb_imem_boot_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cpu_hold, done, error;
    logic [8:0] word_count;

    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_WIDTH(8)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    int         total = 0;
    int         bad   = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic       prev_we = 1'b0;
    logic [7:0] fr[$];

    // Monitor: every write strobe must match the next queued write and never be two cycles wide.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got addr=%h data=%h, none expected", bus.imem_addr, bus.imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.imem_addr !== mon_e.addr || bus.imem_wdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL imem_write got addr=%h data=%h, expected addr=%h data=%h",
                             bus.imem_addr, bus.imem_wdata, mon_e.addr, mon_e.data);
                end
            end
            total++;
            if (prev_we) begin
                bad++;
                $display("FAIL we_single_cycle got imem_we high two cycles, expected one");
            end
        end
        prev_we = bus.imem_we;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            check("ready_in_gap", 32'(bus.in_ready), 32'd1);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL byte_accept got in_ready=0 for 50 cycles, expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], (i == 0) ? 0 : gap);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_imem_we", 32'(bus.imem_we), 32'd0);
        check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // Basic two-word load
        push_wr(8'd0, 32'h20080005);
        push_wr(8'd1, 32'h00000000);
        pulse_start();
        fr = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1_word_count", 32'(word_count), 32'd2);
        check("t1_in_ready", 32'(bus.in_ready), 32'd0);

        // Same frame with 3-cycle valid gaps
        pulse_start();
        check("t2_hold_after_start", 32'(cpu_hold), 32'd1);
        check("t2_done_cleared", 32'(done), 32'd0);
        check("t2_wc_cleared", 32'(word_count), 32'd0);
        push_wr(8'd0, 32'h20080005);
        push_wr(8'd1, 32'h00000000);
        send_frame(3);
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t2_word_count", 32'(word_count), 32'd2);

        // Zero length and over-length both abort
        pulse_start();
        fr = '{8'h00, 8'h00};
        send_frame(0);
        check("t3_len0_error", 32'(error), 32'd1);
        check("t3_len0_hold", 32'(cpu_hold), 32'd1);
        check("t3_len0_done", 32'(done), 32'd0);
        pulse_start();
        check("t3_error_cleared", 32'(error), 32'd0);
        fr = '{8'h01, 8'h01};
        send_frame(0);
        check("t3_len257_error", 32'(error), 32'd1);
        check("t3_len257_hold", 32'(cpu_hold), 32'd1);
        pulse_start();
        check("t3_error_cleared2", 32'(error), 32'd0);

        // Reset after 6 payload bytes of a 3-word frame: only addr 0 written
        push_wr(8'd0, 32'h11223344);
        fr = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], 0);
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        push_wr(8'd0, 32'hDEADBEEF);
        pulse_start();
        fr = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(0);
        check("t4_done", 32'(done), 32'd1);
        check("t4_word_count", 32'(word_count), 32'd1);

        // Reload from DONE
        pulse_start();
        check("t5_hold_during_load", 32'(cpu_hold), 32'd1);
        push_wr(8'd0, 32'h3C011001);
        fr = '{8'h00, 8'h01, 8'h3C, 8'h01, 8'h10, 8'h01};
        send_frame(0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t5_word_count", 32'(word_count), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        push_wr(8'd0, 32'hAA550FF0);
        fr = '{8'h00, 8'h01, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h00};
        send_frame(0);
        check("t6_chk_ok_done", 32'(done), 32'd1);
        check("t6_chk_ok_error", 32'(error), 32'd0);
        pulse_start();
        push_wr(8'd0, 32'hAA550FF0);
        fr = '{8'h00, 8'h01, 8'hAA, 8'h55, 8'h0F, 8'hF0, 8'h01};
        send_frame(0);
        check("t6_chk_bad_error", 32'(error), 32'd1);
        check("t6_chk_bad_hold", 32'(cpu_hold), 32'd1);
        check("t6_chk_bad_done", 32'(done), 32'd0);
`endif

        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Producer side of the instruction stream the CPU decodes: receives a byte-stream load frame, assembles big-endian 32-bit MIPS instruction words and writes them to instruction memory.
- Holds the pipeline CPU stalled (cpu_hold) from reset until a complete, valid program has been written.
- Sits between the host byte link (UART receiver, valid/ready) and the instruction-memory write port.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted program length in words; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a new load from IDLE, DONE or ERR.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  keeps the CPU stalled/reset while high.
- done  output  1  load completed successfully; level.
- error  output  1  load aborted; level.
- word_count  output  ADDR_WIDTH+1  words written in the current load.

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, word_count=0, state IDLE.
- Byte transfer occurs only on a cycle where in_valid and in_ready are both high. in_valid gaps of any length are legal.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N payload bytes, MSB first per word. [CHK byte only with the optional feature.]
- States:
  - IDLE: in_ready=0. start → LEN_HI.
  - LEN_HI: in_ready=1. Byte stored → LEN_LO.
  - LEN_LO: in_ready=1. On the byte, N is formed. N==0 or N>MAX_WORDS → ERR; else → DATA, with byte index=0 and word_count=0.
  - DATA: in_ready=1. Bytes shift into the word register, byte 0 landing in bits [31:24]. On the 4th byte:
    - the next cycle imem_we=1, imem_wdata=word, imem_addr=word_count (pre-increment value); word_count increments in that same cycle;
    - byte index wraps to 0;
    - if this was word N, the FSM leaves DATA for DONE (or CHK) in that same next cycle.
  - DONE: done=1, cpu_hold=0, in_ready=0. The final imem_we coincides with the first DONE cycle.
  - ERR: error=1, cpu_hold=1, in_ready=0.
  - From DONE or ERR, start → LEN_HI. The same edge clears done, error and word_count and sets cpu_hold=1.
- start is ignored in LEN_HI, LEN_LO, DATA and CHK.
- imem_we is never high for more than one consecutive cycle. Total writes per load = N exactly.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Reset mid-load: immediate return to reset values next edge. Already-written memory words are not cleared.
- A start pulse and reset in the same cycle: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after word N the FSM enters CHK (in_ready=1) and accepts one byte.
  - Byte equals the XOR of all 4·N payload bytes → DONE.
  - Otherwise → ERR, and cpu_hold stays 1.
  - The final imem_we still occurs in the first CHK cycle. A mismatch does not undo writes.
- Undefined: no CHK state; DATA goes directly to DONE.

Test Plan:
- Reset, start, stream 00 02 | 20 08 00 05 | 00 00 00 00 →
  - imem_we pulses twice: addr 0 data 0x20080005, then addr 1 data 0x00000000;
  - done=1, cpu_hold=0, word_count=2.
- Same frame with in_valid deasserted for 3 cycles between every byte → identical writes and final state; in_ready stays 1 throughout DATA.
- Length field 00 00, then separately 01 01 with MAX_WORDS=256 → error=1, cpu_hold=1, no imem_we; a new start then clears error.
- Reset asserted after 6 payload bytes of a 3-word frame →
  - next cycle: reset values, only one write (addr 0) ever issued;
  - a following start plus a full 1-word frame writes addr 0 and sets done.
- From DONE, start plus a 1-word frame 3C 01 10 01 → cpu_hold=1 during the load, then a write to addr 0, done=1 again, word_count=1.
- With IMEM_LOADER_CHECKSUM_EN:
  - frame 00 01 AA 55 0F F0 plus CHK byte 00 → done=1;
  - same frame with CHK 01 → error=1, cpu_hold=1, and the single write to addr 0 of 0xAA550FF0 still observed.
